// File: rtl/addsub_seq_accumulator.sv
// Sequential add/subtract accumulator.
// A start pulse arms a run of `count` operands. Each operand arrives over a
// valid/ready handshake and is added to, or subtracted from, a running
// accumulator. The final sum and its flags are then offered downstream over a
// second valid/ready handshake.
module addsub_seq_accumulator #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] remaining;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH-1:0] next_acc;
    logic             next_c;
    logic             next_ovf;
    logic             transfer;

    // The operand port is open only while a run is in progress, so in_ready
    // and busy are pure functions of the state register.
    assign in_ready = (state == ACCUM);
    assign busy     = (state != IDLE);
    assign transfer = in_valid && in_ready;

    // Arithmetic for one operand: new accumulator value, carry/borrow and
    // signed overflow of this single step.
    always_comb begin
        add_sum  = '0;
        next_acc = acc;
        next_c   = 1'b0;
        next_ovf = 1'b0;
        if (in_sub) begin
            next_acc = acc - in_data;
            next_c   = (acc < in_data);
            next_ovf = (acc[WIDTH-1] != in_data[WIDTH-1]) &&
                       (next_acc[WIDTH-1] != acc[WIDTH-1]);
        end else begin
            add_sum  = {1'b0, acc} + {1'b0, in_data};
            next_acc = add_sum[WIDTH-1:0];
            next_c   = add_sum[WIDTH];
            next_ovf = (acc[WIDTH-1] == in_data[WIDTH-1]) &&
                       (next_acc[WIDTH-1] != acc[WIDTH-1]);
        end
    end

    // Run control FSM with registered result, flags and out_valid; a reset
    // mid-run discards everything accumulated so far.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            remaining <= '0;
            result    <= '0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc      <= '0;
                        carry    <= 1'b0;
                        overflow <= 1'b0;
                        if (count != '0) begin
                            remaining <= count;
                            state     <= ACCUM;
                        end else begin
                            remaining <= '0;
                            result    <= '0;
                            zero      <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                ACCUM: begin
                    if (transfer) begin
                        acc       <= next_acc;
                        carry     <= next_c;
                        overflow  <= overflow | next_ovf;
                        remaining <= remaining - 1'b1;
                        if (remaining == CNT_W'(1)) begin
                            result    <= next_acc;
                            zero      <= (next_acc == '0);
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_seq_accumulator.sv
// Directed testbench for addsub_seq_accumulator (WIDTH=4, CNT_W=4).
module tb_addsub_seq_accumulator;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] count;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       in_sub;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] result;
    logic       carry;
    logic       overflow;
    logic       zero;
    logic       busy;

    int checks;
    int failures;

    addsub_seq_accumulator #(
        .WIDTH(4),
        .CNT_W(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .count    (count),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sub   (in_sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .carry    (carry),
        .overflow (overflow),
        .zero     (zero),
        .busy     (busy)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one cycle with the given run length.
    task automatic applyStimulus(input logic [3:0] cnt);
        start = 1'b1;
        count = cnt;
        tick();
        start = 1'b0;
        count = 4'h0;
    endtask

    // Offer one operand and hold it until the stage accepts it (bounded).
    task automatic sendOperand(input string tag, input logic [3:0] d, input logic s);
        int n;
        n = 0;
        in_data  = d;
        in_sub   = s;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checkOutput({tag, "_in_ready"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        in_data  = 4'hF;
        in_sub   = 1'b0;
    endtask

    task automatic checkResult(input string tag, input logic [3:0] r, input logic c,
                               input logic o, input logic z);
        checkOutput({tag, "_out_valid"}, out_valid, 1);
        checkOutput({tag, "_result"}, result, r);
        checkOutput({tag, "_carry"}, carry, c);
        checkOutput({tag, "_overflow"}, overflow, o);
        checkOutput({tag, "_zero"}, zero, z);
        checkOutput({tag, "_in_ready_done"}, in_ready, 0);
    endtask

    // Accept the result for one cycle and confirm the return to IDLE.
    task automatic consume(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput({tag, "_drop_valid"}, out_valid, 0);
        checkOutput({tag, "_idle_busy"}, busy, 0);
    endtask

    // Directed sequence of runs with hand-computed expected values.
    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        start     = 1'b0;
        count     = 4'h0;
        in_valid  = 1'b0;
        in_data   = 4'h0;
        in_sub    = 1'b0;
        out_ready = 1'b0;

        tick();
        tick();
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_result", result, 0);
        checkOutput("rst_flags", {carry, overflow, zero}, 3'b000);
        rst = 1'b0;
        tick();

        // Run 1: +5 +7 -2 -> A, overflow from 5+7
        applyStimulus(4'd3);
        checkOutput("r1_busy", busy, 1);
        checkOutput("r1_in_ready", in_ready, 1);
        sendOperand("r1_op0", 4'd5, 1'b0);
        sendOperand("r1_op1", 4'd7, 1'b0);
        checkOutput("r1_not_done", out_valid, 0);
        sendOperand("r1_op2", 4'd2, 1'b1);
        checkResult("r1", 4'hA, 1'b0, 1'b1, 1'b0);
        consume("r1");

        // Run 2: +9, gap, +9 -> 2, carry, overflow
        applyStimulus(4'd2);
        sendOperand("r2_op0", 4'd9, 1'b0);
        in_data = 4'h7;
        in_sub  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("r2_gap_valid", out_valid, 0);
            checkOutput("r2_gap_ready", in_ready, 1);
        end
        sendOperand("r2_op1", 4'd9, 1'b0);
        checkResult("r2", 4'h2, 1'b1, 1'b1, 1'b0);
        consume("r2");

        // Zero-length run goes straight to DONE without opening the input
        applyStimulus(4'd0);
        checkResult("r0", 4'h0, 1'b0, 1'b0, 1'b1);
        checkOutput("r0_busy", busy, 1);
        consume("r0");

        // +3 -3 -> 0, zero flag
        applyStimulus(4'd2);
        sendOperand("rz_op0", 4'd3, 1'b0);
        sendOperand("rz_op1", 4'd3, 1'b1);
        checkResult("rz", 4'h0, 1'b0, 1'b0, 1'b1);
        consume("rz");

        // -2 -> 14 with borrow, then hold DONE with start pulses
        applyStimulus(4'd1);
        sendOperand("rb_op0", 4'd2, 1'b1);
        checkResult("rb", 4'hE, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            start = (i % 2 == 0);
            count = 4'd1;
            tick();
            checkResult("hold", 4'hE, 1'b1, 1'b0, 1'b0);
        end
        start = 1'b0;
        count = 4'd0;
        consume("hold");
        tick();
        checkOutput("hold_after_idle", in_ready, 0);

        // Reset mid-run after 1 of 3 operands (0-8: borrow and overflow)
        applyStimulus(4'd3);
        sendOperand("rr_op0", 4'd8, 1'b1);
        checkOutput("rr_pre_busy", busy, 1);
        rst = 1'b1;
        #1;
        checkOutput("rr_out_valid", out_valid, 0);
        checkOutput("rr_busy", busy, 0);
        checkOutput("rr_in_ready", in_ready, 0);
        checkOutput("rr_result", result, 0);
        checkOutput("rr_flags", {carry, overflow, zero}, 3'b000);
        #2;
        rst = 1'b0;
        tick();
        checkOutput("rr_still_idle", out_valid, 0);

        // Fresh run after reset: +6 -> 6
        applyStimulus(4'd1);
        sendOperand("rf_op0", 4'd6, 1'b0);
        checkResult("rf", 4'h6, 1'b0, 1'b0, 1'b0);
        consume("rf");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
